// File: rtl/datapath_fwd.sv
`default_nettype none
// ============================================================================
// Module      : datapath_fwd
// Description : Three-stage ID/EXE/WB integer datapath with EXE and WB operand
//               forwarding, so dependent instructions issue back-to-back.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_fwd #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic             inst_valid,
    input  logic             en,
    output logic [DSIZE-1:0] aluout2,
    output logic [ASIZE-1:0] waddr2,
    output logic             out_valid,
    output logic [1:0]       fwd_hit
);

    localparam int c_DEPTH = 2 ** ASIZE;

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SLT = 3'd5;
    localparam logic [2:0] c_OP_SLL = 3'd6;

    logic [DSIZE-1:0] r_regs [c_DEPTH];

    logic             r_ex_valid;
    logic [2:0]       r_ex_op;
    logic [DSIZE-1:0] r_ex_a;
    logic [DSIZE-1:0] r_ex_b;
    logic [ASIZE-1:0] r_ex_dest;

    logic             r_wb_valid;
    logic [DSIZE-1:0] r_wb_data;
    logic [ASIZE-1:0] r_wb_dest;

    logic [5:0]       w_opcode;
    logic [ASIZE-1:0] w_rs;
    logic [ASIZE-1:0] w_rt;
    logic [ASIZE-1:0] w_rd;
    logic [DSIZE-1:0] w_imm;
    logic [2:0]       w_aluop;
    logic             w_alusrc;
    logic             w_wen;
    logic [ASIZE-1:0] w_dest;
    logic             w_a_ex, w_a_wb, w_b_ex, w_b_wb;
    logic [DSIZE-1:0] w_rs_data;
    logic [DSIZE-1:0] w_rt_data;
    logic [DSIZE-1:0] w_opb;
    logic [DSIZE-1:0] w_alu_out;

    // ---------------------------------------------------------------- ID stage
    assign w_opcode = inst[31:26];
    assign w_rs     = inst[21 +: ASIZE];
    assign w_rt     = inst[16 +: ASIZE];
    assign w_rd     = inst[11 +: ASIZE];
    assign w_imm    = {{(DSIZE-16){inst[15]}}, inst[15:0]};
    assign w_aluop  = w_opcode[2:0];
    assign w_alusrc = w_opcode[5];
    assign w_wen    = inst_valid & (w_opcode[4:3] != 2'b11);
    assign w_dest   = w_alusrc ? w_rt : w_rd;

    // EXE-stage valid already folds in wen, so non-writing instructions never forward
    assign w_a_ex = r_ex_valid && (r_ex_dest == w_rs) && (w_rs != '0);
    assign w_a_wb = r_wb_valid && (r_wb_dest == w_rs) && (w_rs != '0);
    assign w_b_ex = r_ex_valid && (r_ex_dest == w_rt) && (w_rt != '0);
    assign w_b_wb = r_wb_valid && (r_wb_dest == w_rt) && (w_rt != '0);

    assign w_rs_data = (w_rs == '0) ? '0 :
                       w_a_ex       ? w_alu_out :
                       w_a_wb       ? r_wb_data : r_regs[w_rs];
    assign w_rt_data = (w_rt == '0) ? '0 :
                       w_b_ex       ? w_alu_out :
                       w_b_wb       ? r_wb_data : r_regs[w_rt];
    assign w_opb     = w_alusrc ? w_imm : w_rt_data;

    // Source B only counts as forwarded when rt data, not the immediate, is the operand
    assign fwd_hit = {inst_valid & ~w_alusrc & (w_b_ex | w_b_wb),
                      inst_valid & (w_a_ex | w_a_wb)};

    // --------------------------------------------------------------- EXE stage
    always_comb begin
        w_alu_out = '0;
        case (r_ex_op)
            c_OP_ADD: w_alu_out = r_ex_a + r_ex_b;
            c_OP_SUB: w_alu_out = r_ex_a - r_ex_b;
            c_OP_AND: w_alu_out = r_ex_a & r_ex_b;
            c_OP_OR:  w_alu_out = r_ex_a | r_ex_b;
            c_OP_XOR: w_alu_out = r_ex_a ^ r_ex_b;
            c_OP_SLT: w_alu_out = {{(DSIZE-1){1'b0}}, ($signed(r_ex_a) < $signed(r_ex_b))};
            c_OP_SLL: w_alu_out = r_ex_a << r_ex_b[4:0];
            default:  w_alu_out = r_ex_a >> r_ex_b[4:0];
        endcase
    end

    // ------------------------------------------------- pipeline and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_dest  <= '0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_dest  <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (en) begin
            r_ex_valid <= w_wen;
            r_ex_op    <= w_aluop;
            r_ex_a     <= w_rs_data;
            r_ex_b     <= w_opb;
            r_ex_dest  <= w_dest;
            r_wb_valid <= r_ex_valid;
            r_wb_data  <= w_alu_out;
            r_wb_dest  <= r_ex_dest;
            if (r_wb_valid && (r_wb_dest != '0)) begin
                r_regs[r_wb_dest] <= r_wb_data;
            end
        end
    end

    assign aluout2   = r_wb_data;
    assign waddr2    = r_wb_dest;
    assign out_valid = r_wb_valid;

endmodule
`default_nettype wire

// File: tb/tb_datapath_fwd.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_fwd
// Description : Directed self-checking bench for datapath_fwd.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_fwd;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        en;
    logic [31:0] aluout2;
    logic [4:0]  waddr2;
    logic        out_valid;
    logic [1:0]  fwd_hit;

    int n_cmp  = 0;
    int n_fail = 0;

    datapath_fwd #(.DSIZE(32), .ASIZE(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst),
        .inst_valid (inst_valid),
        .en         (en),
        .aluout2    (aluout2),
        .waddr2     (waddr2),
        .out_valid  (out_valid),
        .fwd_hit    (fwd_hit)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0];
        t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input int rs, input int rt,
                                          input int rd);
        logic [4:0] s, t, d;
        s = rs[4:0];
        t = rt[4:0];
        d = rd[4:0];
        return {op, s, t, d, 11'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] i, input logic v);
        inst       = i;
        inst_valid = v;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] d, input logic [4:0] a,
                           input logic v);
        chk({tag, ".aluout2"}, aluout2, d);
        chk({tag, ".waddr2"}, {27'b0, waddr2}, {27'b0, a});
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
    endtask

    // Opcodes: bit5 = immediate form, bits[2:0] = ALU op
    localparam logic [5:0] c_ADD  = 6'h00;
    localparam logic [5:0] c_SUB  = 6'h01;
    localparam logic [5:0] c_SLT  = 6'h05;
    localparam logic [5:0] c_NOP  = 6'h18;
    localparam logic [5:0] c_ADDI = 6'h20;

    logic [31:0] t_inst [10];
    logic [31:0] t_data [10];
    logic [4:0]  t_addr [10];

    initial begin
        rst = 1'b1; en = 1'b1; inst = '0; inst_valid = 1'b0;
        cycle(); cycle();
        rst = 1'b0;
        #1;
        chk_out("reset", 32'h0, 5'd0, 1'b0);
        chk("reset.fwd_hit", {30'b0, fwd_hit}, 32'h0);

        // Two independent ADDIs retire on consecutive cycles
        issue(enc_i(c_ADDI, 0, 1, 16'd5), 1'b1); cycle();
        issue(enc_i(c_ADDI, 0, 2, 16'd7), 1'b1); cycle();
        issue('0, 1'b0);
        chk_out("addi_r1", 32'd5, 5'd1, 1'b1);
        cycle();
        chk_out("addi_r2", 32'd7, 5'd2, 1'b1);

        // EXE forwarding on both sources
        issue(enc_i(c_ADDI, 0, 1, 16'd3), 1'b1); cycle();
        issue(enc_r(c_ADD, 1, 1, 2), 1'b1);
        chk("exe_fwd.fwd_hit", {30'b0, fwd_hit}, 32'd3);
        cycle();
        issue('0, 1'b0);
        chk_out("exe_fwd_src", 32'd3, 5'd1, 1'b1);
        cycle();
        chk_out("exe_fwd_add", 32'd6, 5'd2, 1'b1);

        // WB forwarding across a non-writing instruction
        issue(enc_i(c_ADDI, 0, 1, 16'd11), 1'b1); cycle();
        issue(enc_i(c_NOP, 0, 9, 16'd4), 1'b1); cycle();
        issue(enc_r(c_SUB, 1, 0, 3), 1'b1);
        chk("wb_fwd.fwd_hit", {30'b0, fwd_hit}, 32'd1);
        cycle();
        issue('0, 1'b0);
        chk("nop.out_valid", {31'b0, out_valid}, 32'd0);
        cycle();
        chk_out("wb_fwd_sub", 32'd11, 5'd3, 1'b1);

        // Register 0 is never forwarded nor written
        issue(enc_i(c_ADDI, 0, 0, 16'd9), 1'b1); cycle();
        issue(enc_r(c_ADD, 0, 0, 4), 1'b1);
        chk("r0.fwd_hit", {30'b0, fwd_hit}, 32'd0);
        cycle();
        issue('0, 1'b0);
        chk_out("r0_addi", 32'd9, 5'd0, 1'b1);
        cycle();
        chk_out("r0_add", 32'd0, 5'd4, 1'b1);

        // Freeze for three cycles with a dependent instruction waiting in ID
        issue(enc_i(c_ADDI, 0, 5, 16'd21), 1'b1); cycle();
        issue(enc_i(c_ADDI, 0, 6, 16'd22), 1'b1); cycle();
        chk_out("pre_freeze", 32'd21, 5'd5, 1'b1);
        en = 1'b0;
        issue(enc_r(c_ADD, 5, 6, 7), 1'b1);
        chk("freeze.fwd_hit", {30'b0, fwd_hit}, 32'd3);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk_out("frozen", 32'd21, 5'd5, 1'b1);
        end
        en = 1'b1;
        cycle();
        chk_out("resume_r6", 32'd22, 5'd6, 1'b1);
        issue(enc_r(c_ADD, 5, 0, 8), 1'b1);
        chk("rf_r5.fwd_hit", {30'b0, fwd_hit}, 32'd0);
        cycle();
        issue('0, 1'b0);
        chk_out("resume_r7", 32'd43, 5'd7, 1'b1);
        cycle();
        chk_out("rf_r5_read", 32'd21, 5'd8, 1'b1);

        // Reset with two instructions in flight
        issue(enc_i(c_ADDI, 0, 9, 16'd1), 1'b1); cycle();
        issue(enc_i(c_ADDI, 0, 10, 16'd2), 1'b1); cycle();
        issue('0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_out("rst_flight", 32'd0, 5'd0, 1'b0);
        issue(enc_r(c_ADD, 9, 10, 11), 1'b1);
        chk("rst_read.fwd_hit", {30'b0, fwd_hit}, 32'd0);
        cycle();
        issue(enc_r(c_ADD, 2, 3, 12), 1'b1); cycle();
        issue('0, 1'b0);
        chk_out("rst_r9_r10", 32'd0, 5'd11, 1'b1);
        cycle();
        chk_out("rst_r2_r3", 32'd0, 5'd12, 1'b1);

        // ALU operation table, issued back-to-back
        t_inst[0] = enc_i(c_ADDI, 0, 1, 16'd12);     t_data[0] = 32'd12;         t_addr[0] = 5'd1;
        t_inst[1] = enc_i(c_ADDI, 0, 2, 16'hFFFD);   t_data[1] = 32'hFFFF_FFFD;  t_addr[1] = 5'd2;
        t_inst[2] = enc_i(6'h22, 1, 3, 16'd10);      t_data[2] = 32'd8;          t_addr[2] = 5'd3;
        t_inst[3] = enc_i(6'h23, 1, 4, 16'd3);       t_data[3] = 32'd15;         t_addr[3] = 5'd4;
        t_inst[4] = enc_i(6'h24, 1, 5, 16'd5);       t_data[4] = 32'd9;          t_addr[4] = 5'd5;
        t_inst[5] = enc_i(6'h25, 2, 6, 16'd1);       t_data[5] = 32'd1;          t_addr[5] = 5'd6;
        t_inst[6] = enc_i(6'h26, 1, 7, 16'd2);       t_data[6] = 32'd48;         t_addr[6] = 5'd7;
        t_inst[7] = enc_i(6'h27, 2, 8, 16'd28);      t_data[7] = 32'h0000_000F;  t_addr[7] = 5'd8;
        t_inst[8] = enc_i(6'h21, 1, 9, 16'd20);      t_data[8] = 32'hFFFF_FFF8;  t_addr[8] = 5'd9;
        t_inst[9] = enc_r(c_SLT, 1, 2, 10);          t_data[9] = 32'd0;          t_addr[9] = 5'd10;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) issue(t_inst[i], 1'b1);
            else        issue('0, 1'b0);
            if (i >= 2) chk_out($sformatf("alu%0d", i - 2), t_data[i-2], t_addr[i-2], 1'b1);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
